// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: arbitrates, registers the operands,
// waits one cycle for the ALU result, then holds that result until the consumer takes it.
//
// state  | meaning
// S_IDLE | waiting for a request; ready goes to the arbitration winner
// S_EXEC | operands registered on the ALU inputs; result captured at end of cycle
// S_RESP | rsp_valid high; result held until rsp_ready
module alu_arbiter #(
    parameter int PRIO_FIXED = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req0_pc,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [31:0] req1_pc,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] alu_pc,
    input  logic [31:0] alu_c,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_c,
    output logic        rsp_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_rr_ptr;
    logic [4:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_pc;
    logic        r_id;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_c;
    logic        r_rsp_zero;

    logic        w_win1;
    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        w_win1 = req1_valid;
        if (req0_valid && req1_valid) begin
            w_win1 = (PRIO_FIXED != 0) ? 1'b0 : r_rr_ptr;
        end
    end

    // rstn gates ready so it drops the instant reset asserts.
    assign w_idle   = rstn && (r_state == S_IDLE);
    assign w_grant0 = w_idle && req0_valid && !w_win1;
    assign w_grant1 = w_idle && req1_valid && w_win1;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= 1'b0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_pc        <= '0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_c     <= '0;
            r_rsp_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_op     <= w_grant1 ? req1_op : req0_op;
                        r_a      <= w_grant1 ? req1_a  : req0_a;
                        r_b      <= w_grant1 ? req1_b  : req0_b;
                        r_pc     <= w_grant1 ? req1_pc : req0_pc;
                        r_id     <= w_grant1;
                        r_rr_ptr <= w_grant0;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_c     <= alu_c;
                    r_rsp_zero  <= alu_zero;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_pc    = r_pc;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_c     = r_rsp_c;
    assign rsp_zero  = r_rsp_zero;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
- REQ-001: Parameter PRIO_FIXED, default 0, arbitration mode: 0 = round-robin, 1 = fixed priority with requester 0 always winning.
- REQ-002: clk  input  1  system clock; all state updates on the rising edge.
- REQ-003: rstn  input  1  asynchronous, active-low reset.
- REQ-004: req0_valid / req1_valid  input  1  requester i holds an ALU operation.
- REQ-005: req0_ready / req1_ready  output  1  requester i's operation is accepted this cycle.
- REQ-006: req0_op / req1_op  input  5  ALUOp code, same encoding as the ALU's ALUOp input.
- REQ-007: req0_a, req0_b, req0_pc / req1_a, req1_b, req1_pc  input  32  operands A and B and the PC for requester i.
- REQ-008: alu_op  output  5  registered ALUOp driven to the shared ALU.
- REQ-009: alu_a, alu_b, alu_pc  output  32  registered operands driven to the shared ALU.
- REQ-010: alu_c  input  32  ALU result C.
- REQ-011: alu_zero  input  1  ALU Zero flag.
- REQ-012: rsp_valid  output  1  result available.
- REQ-013: rsp_ready  input  1  consumer takes the result.
- REQ-014: rsp_id  output  1  index of the requester that owns the result.
- REQ-015: rsp_c  output  32  captured ALU result.
- REQ-016: rsp_zero  output  1  captured Zero flag.

Function
- REQ-017: FSM SHALL have exactly three states: IDLE, EXEC, RESP.
- REQ-018: IDLE SHALL assert reqI_ready combinationally only for the arbitration winner; the ready for the other requester is 0.
- REQ-019: IDLE SHALL assert no ready when neither requester is valid.
- REQ-020: Accept SHALL occur when reqI_valid & reqI_ready in IDLE.
- REQ-021: On accept, reqI_op, reqI_a, reqI_b and reqI_pc SHALL be latched into alu_op, alu_a, alu_b and alu_pc, the requester index SHALL be latched, and the FSM SHALL go to EXEC.
- REQ-022: Arbitration with a single valid requester: that requester wins.
- REQ-023: Arbitration with both valid and PRIO_FIXED=1: requester 0 wins.
- REQ-024: Arbitration with both valid and PRIO_FIXED=0: the requester not granted at the most recent accept wins.
- REQ-025: After reset the round-robin pointer SHALL favour requester 0.
- REQ-026: The round-robin pointer SHALL update only on accept, never on idle cycles or in EXEC/RESP.
- REQ-027: EXEC SHALL last exactly one cycle; at its end alu_c and alu_zero SHALL be captured into rsp_c and rsp_zero, and the FSM SHALL go to RESP.
- REQ-028: RESP SHALL assert rsp_valid=1 and hold rsp_id, rsp_c and rsp_zero stable until rsp_ready=1.
- REQ-029: On rsp_ready=1 in RESP the FSM SHALL go to IDLE, and no accept is possible in that same cycle.
- REQ-030: Latency SHALL be accept in cycle N, rsp_valid high in cycle N+2, and minimum issue interval 3 cycles.
- REQ-031: alu_op, alu_a, alu_b and alu_pc SHALL hold their last latched values outside accept cycles, so the ALU inputs stay stable through EXEC and RESP.
- REQ-032: Requester valid SHALL be held until ready; a valid deasserted before ready SHALL cause no operation and no pointer change.
- REQ-033: Valid from either requester during EXEC or RESP SHALL be ignored (ready=0), with the request pending and no loss.
- REQ-034: rsp_ready asserted outside RESP SHALL have no effect.
- REQ-035: Width rule: the block SHALL not modify operands or results, passing 32-bit values bit-exact with no sign handling.

Reset
- REQ-036: rstn=0 SHALL asynchronously force IDLE with round-robin pointer = requester 0.
- REQ-037: rstn=0 SHALL asynchronously clear rsp_valid, rsp_id, rsp_c, rsp_zero, alu_op, alu_a, alu_b and alu_pc to 0.
- REQ-038: rstn=0 SHALL asynchronously drive req0_ready and req1_ready to 0.
- REQ-039: Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response ever issued.
- REQ-040: The first accept after rstn deasserts SHALL be possible on the first rising edge with rstn=1.

Verification
- REQ-041: req0 add, A=5, B=7, accepted at cycle N -> rsp_valid=1 at N+2, rsp_id=0, rsp_c=12, rsp_zero=0.
- REQ-042: PRIO_FIXED=0, both requesters valid continuously, req0 sub 9-9, req1 add 1+2, rsp_ready=1 -> grant order 0,1,0,1; responses rsp_c=0 with rsp_zero=1, then rsp_c=3 with rsp_zero=0.
- REQ-043: PRIO_FIXED=1, same stimulus as REQ-042 -> only requester 0 is ever granted and req1_ready stays 0.
- REQ-044: rsp_ready held 0 for 4 cycles in RESP -> rsp_valid, rsp_id and rsp_c stable for all 4 cycles, req0_ready and req1_ready stay 0, and exactly one response is seen after rsp_ready=1.
- REQ-045: rstn pulsed low mid-EXEC -> rsp_valid never rises for that operation, all outputs read 0, and the next simultaneous request grants requester 0.
- REQ-046: req1 alone valid after a req1 grant -> req1 is granted again, since the pointer does not block a lone requester.
